// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared defaults, FSM states and coefficient type
// for the two-multiplier FIR sequencer (fir_seq_ctrl, fir_cof_bank).
package fir_ctrl_pkg;

  localparam int DEF_CLK_PER_SMP = 16;
  localparam int DEF_NTAP        = 32;
  localparam int DEF_CW          = 12;
  localparam int DEF_PIPE        = 2;

  typedef logic signed [DEF_CW-1:0] cof_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SWAP_PEND
  } state_t;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if: coefficient reload port (valid/ready writes,
// commit pulse) plus bank status. master = software, slave = block.
interface fir_seq_ctrl_if
  import fir_ctrl_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int AW = $clog2(DEF_NTAP)
);

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [AW-1:0]        cfg_addr;
  logic signed [CW-1:0] cfg_data;
  logic                 cfg_commit;
  logic                 bank;
  logic                 swap_pend;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    output cfg_commit,
    input  cfg_ready,
    input  bank,
    input  swap_pend
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    input  cfg_commit,
    output cfg_ready,
    output bank,
    output swap_pend
  );

endinterface

// File: rtl/fir_cof_bank.sv
// fir_cof_bank: double-buffered NTAP x CW coefficient store.
// Ports: i_we/i_waddr/i_wdata write the shadow bank, i_swap flips
// the active bank, i_ridx reads taps i_ridx and i_ridx+CLK_PER_SMP
// (registered, o_rd_a/o_rd_b), o_bank is the active bank index.
module fir_cof_bank
  import fir_ctrl_pkg::*;
#(
  parameter int CLK_PER_SMP = DEF_CLK_PER_SMP,
  parameter int NTAP        = DEF_NTAP,
  parameter int CW          = DEF_CW,
  localparam int PW         = $clog2(CLK_PER_SMP),
  localparam int AW         = $clog2(NTAP)
)(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic signed [CW-1:0] i_wdata,
  input  logic                 i_swap,
  input  logic [PW-1:0]        i_ridx,
  output logic                 o_bank,
  output logic signed [CW-1:0] o_rd_a,
  output logic signed [CW-1:0] o_rd_b
);

  logic signed [CW-1:0] r_mem [2][NTAP];
  logic                 r_bank;
  logic signed [CW-1:0] r_rd_a;
  logic signed [CW-1:0] r_rd_b;

  logic [AW-1:0] w_ra;
  logic [AW-1:0] w_rb;
  logic          w_wen;

  assign w_ra  = AW'(i_ridx);
  assign w_rb  = w_ra + AW'(CLK_PER_SMP);
  assign w_wen = i_we && (int'(i_waddr) < NTAP);

  // Write and swap on the same edge: the write still targets the
  // old shadow, which then becomes active.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bank <= 1'b0;
      r_rd_a <= '0;
      r_rd_b <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int t = 0; t < NTAP; t++) begin
          r_mem[b][t] <= '0;
        end
      end
    end else begin
      if (w_wen) begin
        r_mem[~r_bank][i_waddr] <= i_wdata;
      end
      if (i_swap) begin
        r_bank <= ~r_bank;
      end
      r_rd_a <= r_mem[r_bank][w_ra];
      r_rd_b <= r_mem[r_bank][w_rb];
    end
  end

  assign o_bank = r_bank;
  assign o_rd_a = r_rd_a;
  assign o_rd_b = r_rd_b;

endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: FIR sequencer - FSM, phase counter, strobes and
// coefficient serving. Ports: i_clk, i_rst_n (sync, low), i_en;
// cfg (reload port, slave); o_smp_stb, o_tap_idx, o_cof_a,
// o_cof_b, o_acc_clr, o_out_stb toward the datapath.
module fir_seq_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int CLK_PER_SMP = DEF_CLK_PER_SMP,
  parameter int NTAP        = DEF_NTAP,
  parameter int CW          = DEF_CW,
  parameter int PIPE        = DEF_PIPE,
  localparam int PW         = $clog2(CLK_PER_SMP)
)(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  fir_seq_ctrl_if.slave        cfg,
  output logic                 o_smp_stb,
  output logic [PW-1:0]        o_tap_idx,
  output logic signed [CW-1:0] o_cof_a,
  output logic signed [CW-1:0] o_cof_b,
  output logic                 o_acc_clr,
  output logic                 o_out_stb
);

  localparam logic [PW-1:0] LAST   = PW'(CLK_PER_SMP - 1);
  localparam logic [PW-1:0] STB_PH = PW'(PIPE);

  state_t        r_state;
  state_t        w_nxt;
  logic [PW-1:0] r_phase;
  logic          r_first;

  logic w_active;
  logic w_last;
  logic w_ready;
  logic w_wr;
  logic w_swap;
  logic w_clr;
  logic w_bank;

  assign w_active = (r_state != IDLE);
  assign w_last   = (r_phase == LAST);
  assign w_ready  = (r_state != SWAP_PEND);
  assign w_wr     = cfg.cfg_valid && w_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Dropping en always executes any swap owed, so software never
  // sees a commit lost across a stop.
  always_comb begin
    w_nxt  = r_state;
    w_swap = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_swap = cfg.cfg_commit;
        if (i_en) begin
          w_nxt = RUN;
        end
      end
      RUN: begin
        if (!i_en) begin
          w_nxt  = IDLE;
          w_swap = cfg.cfg_commit;
        end else if (cfg.cfg_commit) begin
          w_nxt = SWAP_PEND;
        end
      end
      SWAP_PEND: begin
        if (!i_en) begin
          w_nxt  = IDLE;
          w_swap = 1'b1;
        end else if (w_last) begin
          w_nxt  = RUN;
          w_swap = 1'b1;
        end
      end
      default: begin
        w_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase <= '0;
    end else if (w_active && i_en) begin
      r_phase <= w_last ? '0 : r_phase + 1'b1;
    end else begin
      r_phase <= '0;
    end
  end

  // Held set while idle; the first frame's accumulator holds
  // products of an unfilled delay line, so its output is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_first <= 1'b1;
    end else if (!w_active) begin
      r_first <= 1'b1;
    end else if (w_last && i_en) begin
      r_first <= 1'b0;
    end
  end

  assign w_clr     = w_active && (r_phase == STB_PH);
  assign o_smp_stb = w_active && w_last;
  assign o_acc_clr = w_clr;
  assign o_out_stb = w_clr && !r_first;
  assign o_tap_idx = r_phase;

  fir_cof_bank #(
    .CLK_PER_SMP (CLK_PER_SMP),
    .NTAP        (NTAP),
    .CW          (CW)
  ) u_bank (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_wr),
    .i_waddr (cfg.cfg_addr),
    .i_wdata (cfg.cfg_data),
    .i_swap  (w_swap),
    .i_ridx  (r_phase),
    .o_bank  (w_bank),
    .o_rd_a  (o_cof_a),
    .o_rd_b  (o_cof_b)
  );

  assign cfg.cfg_ready = w_ready;
  assign cfg.bank      = w_bank;
  assign cfg.swap_pend = (r_state == SWAP_PEND);

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: scoreboard bench for fir_seq_ctrl with a
// cycle-level behavioural model, directed plan plus random traffic.
module tb_fir_seq_ctrl;
  import fir_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic smp_stb;
  logic acc_clr;
  logic out_stb;
  logic [3:0] tap_idx;
  logic signed [11:0] cof_a;
  logic signed [11:0] cof_b;

  always #5 clk = ~clk;

  fir_seq_ctrl_if cfg_if ();

  fir_seq_ctrl dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .cfg       (cfg_if.slave),
    .o_smp_stb (smp_stb),
    .o_tap_idx (tap_idx),
    .o_cof_a   (cof_a),
    .o_cof_b   (cof_b),
    .o_acc_clr (acc_clr),
    .o_out_stb (out_stb)
  );

  typedef struct packed {
    logic        smp;
    logic        acc;
    logic        out;
    logic        ready;
    logic        pend;
    logic        bank;
    logic [3:0]  tap;
    logic [11:0] ca;
    logic [11:0] cb;
  } obs_t;

  obs_t sb[$];
  int   out_cyc[$];
  int   smp_cyc[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   k = 0;

  // Reference model: run flag + start cycle, phase by arithmetic.
  bit                 m_run = 0;
  int                 m_t0 = 0;
  bit                 m_pend = 0;
  bit                 m_bank = 0;
  logic signed [11:0] m_mem [2][32];
  logic signed [11:0] m_ca = 0;
  logic signed [11:0] m_cb = 0;

  function automatic int m_phase(int c);
    return m_run ? (c - m_t0) % 16 : 0;
  endfunction

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
  endfunction

  task automatic model_step();
    int ph;
    if (!rst_n) begin
      m_run = 0;
      m_pend = 0;
      m_bank = 0;
      m_ca = 0;
      m_cb = 0;
      for (int b = 0; b < 2; b++)
        for (int t = 0; t < 32; t++) m_mem[b][t] = 0;
    end else begin
      ph = m_phase(k);
      m_ca = m_mem[m_bank][ph];
      m_cb = m_mem[m_bank][ph + 16];
      if (cfg_if.cfg_valid && !m_pend)
        m_mem[m_bank ^ 1'b1][cfg_if.cfg_addr] = cfg_if.cfg_data;
      if (!m_run) begin
        if (cfg_if.cfg_commit) m_bank = m_bank ^ 1'b1;
        if (en) begin
          m_run = 1;
          m_t0 = k + 1;
        end
      end else if (!en) begin
        if (m_pend || cfg_if.cfg_commit) m_bank = m_bank ^ 1'b1;
        m_pend = 0;
        m_run = 0;
      end else if (m_pend) begin
        if (ph == 15) begin
          m_bank = m_bank ^ 1'b1;
          m_pend = 0;
        end
      end else if (cfg_if.cfg_commit) begin
        m_pend = 1;
      end
    end
    k++;
  endtask

  task automatic tick();
    obs_t e;
    int ph;
    @(posedge clk);
    model_step();
    ph = m_phase(k);
    e.smp = m_run && ph == 15;
    e.acc = m_run && ph == 2;
    e.out = m_run && ph == 2 && (k - m_t0) >= 16;
    e.ready = !m_pend;
    e.pend = m_pend;
    e.bank = m_bank;
    e.tap = 4'(ph);
    e.ca = m_ca;
    e.cb = m_cb;
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a.smp = smp_stb;
      a.acc = acc_clr;
      a.out = out_stb;
      a.ready = cfg_if.cfg_ready;
      a.pend = cfg_if.swap_pend;
      a.bank = cfg_if.bank;
      a.tap = tap_idx;
      a.ca = cof_a;
      a.cb = cof_b;
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL outputs cycle %0d: actual %h required %h",
                    k, a, e);
      if (out_stb) out_cyc.push_back(k);
      if (smp_stb) smp_cyc.push_back(k);
    end
  end

  task automatic wait_phase(input int p);
    int n = 0;
    while (m_phase(k) != p && n < 64) begin
      tick();
      n++;
    end
    if (m_phase(k) != p) begin
      n_chk++;
      $display("FAIL wait_phase: actual %0d required %0d",
               m_phase(k), p);
    end
  endtask

  initial begin
    int t_en;
    int tc;
    logic [11:0] acc_or;
    for (int b = 0; b < 2; b++)
      for (int t = 0; t < 32; t++) m_mem[b][t] = 0;
    rst_n = 0;
    en = 0;
    cfg_if.cfg_valid = 0;
    cfg_if.cfg_addr = 0;
    cfg_if.cfg_data = 0;
    cfg_if.cfg_commit = 0;
    repeat (3) tick();
    rst_n = 1;
    while (k < 10) tick();
    chk("rst_ready", int'(cfg_if.cfg_ready), 1);
    chk("rst_cof_a", int'(cof_a), 0);

    // en at cycle 10
    out_cyc.delete();
    smp_cyc.delete();
    en = 1;
    t_en = k;
    repeat (40) tick();
    chk("first_smp", smp_cyc.size() > 0 ? smp_cyc[0] : -1, t_en + 16);
    chk("first_out", out_cyc.size() > 0 ? out_cyc[0] : -1, t_en + 19);
    chk("out_period",
        out_cyc.size() > 1 ? out_cyc[1] - out_cyc[0] : -1, 16);

    // load taps 0/16, commit at phase 5
    cfg_if.cfg_valid = 1;
    cfg_if.cfg_addr = 0;
    cfg_if.cfg_data = -823;
    tick();
    cfg_if.cfg_addr = 16;
    cfg_if.cfg_data = -341;
    tick();
    cfg_if.cfg_valid = 0;
    wait_phase(5);
    cfg_if.cfg_commit = 1;
    tc = k;
    tick();
    cfg_if.cfg_commit = 0;
    chk("pend_set", int'(cfg_if.swap_pend), 1);
    chk("ready_low", int'(cfg_if.cfg_ready), 0);
    while (k < tc + 10) tick();
    chk("pend_ph15", int'(cfg_if.swap_pend), 1);
    tick();
    chk("bank_flip", int'(cfg_if.bank), 1);
    chk("pend_clr", int'(cfg_if.swap_pend), 0);
    tick();
    chk("cof_a_t0", int'(cof_a), -823);
    chk("cof_b_t16", int'(cof_b), -341);

    // write and commit in the same cycle
    wait_phase(8);
    cfg_if.cfg_valid = 1;
    cfg_if.cfg_addr = 3;
    cfg_if.cfg_data = 21;
    cfg_if.cfg_commit = 1;
    tc = k;
    tick();
    cfg_if.cfg_valid = 0;
    cfg_if.cfg_commit = 0;
    while (k < tc + 8) tick();
    chk("bank_back0", int'(cfg_if.bank), 0);
    while (k < tc + 12) tick();
    chk("cof_a_t3", int'(cof_a), 21);

    // valid held through SWAP_PEND must not write
    wait_phase(2);
    cfg_if.cfg_commit = 1;
    tc = k;
    tick();
    cfg_if.cfg_commit = 0;
    cfg_if.cfg_valid = 1;
    cfg_if.cfg_addr = 0;
    cfg_if.cfg_data = 555;
    while (k < tc + 14) tick();
    cfg_if.cfg_valid = 0;
    tick();
    chk("frozen_bank", int'(cfg_if.bank), 1);
    chk("frozen_t0", int'(cof_a), -823);

    // en drop at phase 7 with a swap pending
    wait_phase(3);
    cfg_if.cfg_commit = 1;
    tick();
    cfg_if.cfg_commit = 0;
    wait_phase(7);
    en = 0;
    tick();
    chk("stop_bank", int'(cfg_if.bank), 0);
    chk("stop_tap", int'(tap_idx), 0);
    chk("stop_stb", int'({smp_stb, acc_clr, out_stb}), 0);
    chk("stop_pend", int'(cfg_if.swap_pend), 0);
    repeat (3) tick();
    out_cyc.delete();
    en = 1;
    t_en = k;
    repeat (40) tick();
    chk("reen_out", out_cyc.size() > 0 ? out_cyc[0] : -1, t_en + 19);

    // reset mid-run after writes
    cfg_if.cfg_valid = 1;
    cfg_if.cfg_addr = 5;
    cfg_if.cfg_data = 100;
    tick();
    cfg_if.cfg_addr = 20;
    cfg_if.cfg_data = -7;
    tick();
    cfg_if.cfg_valid = 0;
    repeat (5) tick();
    rst_n = 0;
    en = 0;
    tick();
    rst_n = 1;
    chk("rrst_bank", int'(cfg_if.bank), 0);
    chk("rrst_tap", int'(tap_idx), 0);
    chk("rrst_cof", int'(cof_a | cof_b), 0);
    chk("rrst_ready", int'(cfg_if.cfg_ready), 1);
    en = 1;
    acc_or = 0;
    repeat (18) begin
      tick();
      acc_or = acc_or | cof_a | cof_b;
    end
    chk("bank0_zero", int'(acc_or), 0);
    en = 0;
    tick();
    cfg_if.cfg_commit = 1;
    tick();
    cfg_if.cfg_commit = 0;
    chk("idle_swap", int'(cfg_if.bank), 1);
    en = 1;
    acc_or = 0;
    repeat (18) begin
      tick();
      acc_or = acc_or | cof_a | cof_b;
    end
    chk("bank1_zero", int'(acc_or), 0);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      en = ($urandom_range(0, 39) != 0);
      cfg_if.cfg_valid = 1'($urandom_range(0, 1));
      cfg_if.cfg_addr = 5'($urandom);
      cfg_if.cfg_data = 12'($urandom);
      cfg_if.cfg_commit = ($urandom_range(0, 24) == 0);
      tick();
    end
    cfg_if.cfg_valid = 0;
    cfg_if.cfg_commit = 0;
    repeat (4) tick();
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencer and coefficient manager for the time-multiplexed, two-multiplier FIR datapath. The datapath runs on the 80 MHz master clock at 5 Msps. Each output sample takes 16 clocks, and each clock handles one tap pair (k, k+16) of a 32-tap filter. This block generates the sample-shift strobe, tap index, accumulator controls and output strobe, and serves coefficients from a double-buffered bank. Software reloads the bank through a valid/ready port, and the new bank takes effect only on a frame boundary.

## Interface
Parameters:
- CLK_PER_SMP, 16 — master clocks per filter sample; also the number of tap-pair steps.
- NTAP, 32 — total taps; must equal 2*CLK_PER_SMP.
- CW, 12 — signed coefficient width.
- PIPE, 2 — datapath latency in clocks from tap_idx to product (select register + multiply register).

Ports:
- clk  in  1  master clock (80 MHz); all logic is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  run enable.
- smp_stb  out  1  shift a new input sample into the tap delay line.
- tap_idx  out  4  current tap-pair step, 0..CLK_PER_SMP-1.
- cof_a  out  CW  coefficient for tap tap_idx, registered.
- cof_b  out  CW  coefficient for tap tap_idx+CLK_PER_SMP, registered.
- acc_clr  out  1  accumulator loads the product sum instead of adding it.
- out_stb  out  1  capture the accumulator as the filter output.
- cfg_valid  in  1  coefficient write request.
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
- cfg_addr  in  5  tap address, 0..NTAP-1.
- cfg_data  in  CW  coefficient value.
- cfg_commit  in  1  single-cycle pulse: swap banks at the next frame boundary.
- bank  out  1  index of the active bank.
- swap_pend  out  1  a commit is waiting for the frame boundary.

## Operation
- State machine:
  - IDLE: entered on reset or whenever en=0. phase is held at 0 and all strobes are 0.
  - RUN: entered from IDLE when en=1.
  - SWAP_PEND: entered from RUN on cfg_commit.
  - SWAP_PEND returns to RUN at phase==CLK_PER_SMP-1, when bank flips.
- phase counter: counts 0..CLK_PER_SMP-1 and wraps to 0 in RUN and SWAP_PEND.
  - tap_idx = phase.
- smp_stb: 1 when phase==CLK_PER_SMP-1, i.e. one pulse per frame.
- acc_clr and out_stb: both 1 when phase==PIPE.
  - out_stb is suppressed in the first frame after leaving IDLE. A first_frame flag is set on IDLE→RUN and cleared at the first wrap.
- cof_a and cof_b: registered reads of the active bank at tap_idx and tap_idx+CLK_PER_SMP.
- Coefficient banks: two banks of NTAP x CW registers, all zero at reset. bank=0 at reset.
  - Writes always go to the inactive (shadow) bank. cfg_addr ≥ NTAP is accepted and ignored.
- cfg_ready:
  - 1 in IDLE and RUN.
  - 0 in SWAP_PEND, so the shadow bank is frozen until the swap.
- cfg_valid and cfg_commit in the same cycle: the write lands first, then the commit is registered.
- cfg_commit in IDLE: the swap happens on the next clock.
- cfg_commit in SWAP_PEND is ignored.
- en falls mid-frame: go to IDLE on the next clock and reset phase to 0. A pending swap is executed on that same transition.
- Reset mid-operation: every register returns to its reset value, including both coefficient banks.

## Timing
- Reset values: smp_stb=0, tap_idx=0, cof_a=0, cof_b=0, acc_clr=0, out_stb=0, cfg_ready=1, bank=0, swap_pend=0.
- en rises at cycle t:
  - RUN begins at t+1 with phase=0.
  - The first smp_stb is at t+16.
  - The first out_stb is at t+1+16+PIPE.
- Output rate: one out_stb per 16 clocks, at 5 MHz.
- cof_a and cof_b lag tap_idx by 1 clock.
- Bank flip: occurs on the clock edge after phase==15. The first coefficient from the new bank appears on cof_a/cof_b 1 clock later, for tap 0.
- cfg handshake: 1 write per clock maximum. A write is visible to bank-read logic on the next clock.

## Structure
- Shared package fir_ctrl_pkg holds:
  - the state enum (IDLE, RUN, SWAP_PEND);
  - the default CLK_PER_SMP, NTAP, CW and PIPE;
  - the coefficient typedef (signed CW).
- Sub-module fir_cof_bank: the two-bank register file. It has a write port to the shadow bank, two registered read ports on the active bank, and a swap input.
- fir_seq_ctrl contains the FSM, phase counter, first_frame flag and strobe decode.

## Test plan
- Reset, then en=1 at cycle 10: tap_idx steps 0..15 repeatedly; smp_stb at cycles 26, 42, …; the first out_stb at cycle 29, then every 16 clocks.
- Write tap 0=-823 and tap 16=-341, commit at phase 5: swap_pend=1 and cfg_ready=0 until phase 15; bank=1 next clock; cof_a=-823 and cof_b=-341 when tap_idx=0.
- cfg_valid and cfg_commit in the same cycle (addr 3, data 21): after the swap, the active bank read at tap 3 gives 21.
- cfg_valid held high during SWAP_PEND: no write is accepted; the shadow contents are unchanged after the swap.
- en dropped at phase 7 with a swap pending: IDLE next clock, bank flipped, strobes 0, tap_idx=0. Re-enable: no out_stb in the first frame.
- rst_n low for 1 clock mid-RUN after writes: all outputs return to reset values and both banks read 0.
